// File: rtl/lsu_align.sv
// Load/store aligner in front of a word-wide, big-endian data memory.
// Splits misaligned loads into two word reads and misaligned stores into byte writes.
module lsu_align #(
  parameter int ABits = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_width,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_daddr,
  output logic [31:0] mem_dwdata,
  input  logic [31:0] mem_drdata,
  output logic        mem_dwe,
  output logic [1:0]  mem_dwidth
);

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR, RESP} state_t;

  state_t      state, state_next;
  logic        we_q, sgn_q, err_q;
  logic [1:0]  width_q, cnt_q, byte_idx;
  logic [31:0] addr_q, wdata_q, hi_q, lo_q, word_base, load_word, load_val;
  logic [63:0] pair;
  logic        accept, req_err, misaligned, last_step;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign req_err   = (req_width == 2'b11) || ((req_addr >> ABits) != 32'd0);

  assign misaligned = ((width_q == W_HALF) && addr_q[0]) ||
                      ((width_q == W_WORD) && (addr_q[1:0] != 2'b00));
  assign last_step  = (cnt_q == ((width_q == W_WORD) ? 2'd3 : 2'd1));
  // Misaligned stores emit the most significant byte first, at the lowest address.
  assign byte_idx   = ((width_q == W_WORD) ? 2'd3 : 2'd1) - cnt_q;
  assign word_base  = {addr_q[31:2], 2'b00};

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = req_err ? RESP : (req_we ? WR : RD0);
      RD0:  state_next = misaligned ? RD1 : RESP;
      RD1:  state_next = RESP;
      WR:   if (!misaligned || last_step) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      width_q <= 2'b00;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (accept) begin
          we_q    <= req_we;
          sgn_q   <= req_signed;
          err_q   <= req_err;
          width_q <= req_width;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          cnt_q   <= 2'd0;
          hi_q    <= 32'd0;
          lo_q    <= 32'd0;
        end
        RD0: hi_q  <= mem_drdata;
        RD1: lo_q  <= mem_drdata;
        WR:  cnt_q <= cnt_q + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_daddr  = 32'd0;
    mem_dwdata = 32'd0;
    mem_dwe    = 1'b0;
    mem_dwidth = W_WORD;
    case (state)
      RD0: mem_daddr = word_base;
      RD1: mem_daddr = word_base + 32'd4;
      WR: begin
        mem_dwe = 1'b1;
        if (misaligned) begin
          mem_daddr  = addr_q + {30'd0, cnt_q};
          mem_dwidth = W_BYTE;
          mem_dwdata = {24'd0, wdata_q[{byte_idx, 3'b000} +: 8]};
        end else begin
          mem_daddr  = addr_q;
          mem_dwidth = width_q;
          mem_dwdata = wdata_q;
        end
      end
      default: ;
    endcase
  end

  // The requested bytes start addr[1:0] bytes below the top of {hi, lo}.
  assign pair      = {hi_q, lo_q} << {addr_q[1:0], 3'b000};
  assign load_word = pair[63:32];

  always_comb begin
    case (width_q)
      W_BYTE:  load_val = sgn_q ? {{24{load_word[31]}}, load_word[31:24]}
                                : {24'd0, load_word[31:24]};
      W_HALF:  load_val = sgn_q ? {{16{load_word[31]}}, load_word[31:16]}
                                : {16'd0, load_word[31:16]};
      default: load_val = load_word;
    endcase
  end

  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = ((state == RESP) && !err_q && !we_q) ? load_val : 32'd0;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align: a byte-wide big-endian memory model plus
// scoreboards for responses and memory writes, checked by a negedge monitor.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_daddr, mem_dwdata, mem_drdata;
  logic        mem_dwe;
  logic [1:0]  mem_dwidth;

  lsu_align #(.ABits(13)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_width(req_width), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_daddr(mem_daddr), .mem_dwdata(mem_dwdata), .mem_drdata(mem_drdata),
    .mem_dwe(mem_dwe), .mem_dwidth(mem_dwidth)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } resp_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] data;
  } wr_exp_t;

  resp_exp_t exp_q[$];
  wr_exp_t   wr_q[$];
  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  int        acc_cyc = 0;

  logic [7:0] mem [0:8191];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [12:0] b;
    b = {a[12:2], 2'b00};
    return {mem[b], mem[b + 13'd1], mem[b + 13'd2], mem[b + 13'd3]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: big-endian, writes and reads on the falling edge.
  always @(negedge clk) begin
    if (mem_dwe === 1'b1) begin
      case (mem_dwidth)
        2'b00: mem[mem_daddr[12:0]] <= mem_dwdata[7:0];
        2'b01: begin
          mem[mem_daddr[12:0]]         <= mem_dwdata[15:8];
          mem[mem_daddr[12:0] + 13'd1] <= mem_dwdata[7:0];
        end
        default: begin
          mem[mem_daddr[12:0]]         <= mem_dwdata[31:24];
          mem[mem_daddr[12:0] + 13'd1] <= mem_dwdata[23:16];
          mem[mem_daddr[12:0] + 13'd2] <= mem_dwdata[15:8];
          mem[mem_daddr[12:0] + 13'd3] <= mem_dwdata[7:0];
        end
      endcase
    end
    mem_drdata <= rd_word(mem_daddr);
  end

  // Monitor: pops expected responses and writes whenever the DUT presents them.
  always @(negedge clk) begin
    resp_exp_t   e;
    wr_exp_t     w;
    logic [31:0] mask;
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        check("resp_latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
      end
    end
    if (mem_dwe === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", mem_daddr, 32'hFFFF_FFFF);
      end else begin
        w = wr_q.pop_front();
        mask = (w.width == 2'b00) ? 32'h0000_00FF :
               (w.width == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        check("wr_addr", mem_daddr, w.addr);
        check("wr_width", {30'd0, mem_dwidth}, {30'd0, w.width});
        check("wr_data", mem_dwdata & mask, w.data & mask);
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    mem[a[12:0]]         <= d[31:24];
    mem[a[12:0] + 13'd1] <= d[23:16];
    mem[a[12:0] + 13'd2] <= d[15:8];
    mem[a[12:0] + 13'd3] <= d[7:0];
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [1:0] wd, input logic [31:0] d);
    wr_exp_t w;
    w.addr = a; w.width = wd; w.data = d;
    wr_q.push_back(w);
  endtask

  // Issues one request; returns #1 after the accept edge.
  task automatic send(input logic we, input logic [1:0] wd, input logic sgn,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic expect_resp, input logic [31:0] rdata,
                      input logic err, input int lat);
    resp_exp_t e;
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_send", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_width = wd; req_signed = sgn;
    req_addr = a; req_wdata = d;
    if (expect_resp) begin
      e.rdata = rdata; e.err = err; e.lat = lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("resp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_width = 2'b10;
    req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
    #1;
    preload(32'h100, 32'h1122_3344);
    preload(32'h104, 32'h5566_7788);
    repeat (3) @(posedge clk);

    // Reset values
    @(negedge clk);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mem_dwe", {31'd0, mem_dwe}, 32'd0);
    check("rst_mem_daddr", mem_daddr, 32'd0);
    check("rst_mem_dwdata", mem_dwdata, 32'd0);
    check("rst_mem_dwidth", {30'd0, mem_dwidth}, 32'd2);
    rst_n = 1'b1;

    // 1: aligned word load, one read at 0x100
    send(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 1'b1, 32'h1122_3344, 1'b0, 2);
    @(negedge clk);
    check("lw_rd0_addr", mem_daddr, 32'h100);
    check("lw_rd0_we", {31'd0, mem_dwe}, 32'd0);
    wait_done();

    // 2: misaligned loads
    send(1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 1'b1, 32'h3344_5566, 1'b0, 3);
    @(negedge clk);
    check("mlw_rd0_addr", mem_daddr, 32'h100);
    @(negedge clk);
    check("mlw_rd1_addr", mem_daddr, 32'h104);
    wait_done();
    send(1'b0, 2'b01, 1'b0, 32'h103, 32'd0, 1'b1, 32'h0000_4455, 1'b0, 3);
    wait_done();

    // 3: byte/half extension
    send(1'b0, 2'b00, 1'b1, 32'h107, 32'd0, 1'b1, 32'hFFFF_FF88, 1'b0, 2);
    wait_done();
    send(1'b0, 2'b00, 1'b0, 32'h107, 32'd0, 1'b1, 32'h0000_0088, 1'b0, 2);
    wait_done();
    send(1'b0, 2'b01, 1'b1, 32'h106, 32'd0, 1'b1, 32'h0000_7788, 1'b0, 2);
    wait_done();

    // 4: misaligned word store as four byte writes
    push_wr(32'h101, 2'b00, 32'h0000_00AA);
    push_wr(32'h102, 2'b00, 32'h0000_00BB);
    push_wr(32'h103, 2'b00, 32'h0000_00CC);
    push_wr(32'h104, 2'b00, 32'h0000_00DD);
    send(1'b1, 2'b10, 1'b0, 32'h101, 32'hAABB_CCDD, 1'b1, 32'd0, 1'b0, 5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("msw_ready_low", {31'd0, req_ready}, 32'd0);
    end
    wait_done();
    send(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 1'b1, 32'h11AA_BBCC, 1'b0, 2);
    wait_done();
    send(1'b0, 2'b10, 1'b0, 32'h104, 32'd0, 1'b1, 32'hDD66_7788, 1'b0, 2);
    wait_done();

    // Aligned word store, misaligned half store, readbacks
    push_wr(32'h108, 2'b10, 32'hCAFE_BABE);
    send(1'b1, 2'b10, 1'b0, 32'h108, 32'hCAFE_BABE, 1'b1, 32'd0, 1'b0, 2);
    wait_done();
    push_wr(32'h10B, 2'b00, 32'h0000_00BE);
    push_wr(32'h10C, 2'b00, 32'h0000_00EF);
    send(1'b1, 2'b01, 1'b0, 32'h10B, 32'h0000_BEEF, 1'b1, 32'd0, 1'b0, 3);
    wait_done();
    send(1'b0, 2'b01, 1'b1, 32'h10B, 32'd0, 1'b1, 32'hFFFF_BEEF, 1'b0, 3);
    wait_done();
    send(1'b0, 2'b10, 1'b0, 32'h108, 32'd0, 1'b1, 32'hCAFE_BABE, 1'b0, 2);
    wait_done();

    // 5: errors: invalid width, out-of-range address
    send(1'b1, 2'b11, 1'b0, 32'h100, 32'h1234_5678, 1'b1, 32'd0, 1'b1, 1);
    check("err_width_no_we", {31'd0, mem_dwe}, 32'd0);
    wait_done();
    send(1'b0, 2'b10, 1'b0, 32'h2000, 32'd0, 1'b1, 32'd0, 1'b1, 1);
    check("err_addr_no_we", {31'd0, mem_dwe}, 32'd0);
    wait_done();

    // 6: reset after two byte writes of a misaligned store
    preload(32'h100, 32'h1122_3344);
    preload(32'h104, 32'h5566_7788);
    push_wr(32'h101, 2'b00, 32'h0000_00AA);
    push_wr(32'h102, 2'b00, 32'h0000_00BB);
    send(1'b1, 2'b10, 1'b0, 32'h101, 32'hAABB_CCDD, 1'b0, 32'd0, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_mid_dwe", {31'd0, mem_dwe}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("rst_mid_mem100", rd_word(32'h100), 32'h11AA_BB44);
    check("rst_mid_mem104", rd_word(32'h104), 32'h5566_7788);
    check("pending_writes", 32'(wr_q.size()), 32'd0);
    check("pending_resps", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store unit sitting directly upstream of main data memory. Accepts one core load/store request at a time.
- Drives the memory data port (address, write data, write enable, width) and returns a sign- or zero-extended load result.
- Handles misaligned halfword/word accesses in hardware:
  - misaligned reads become two aligned word reads;
  - misaligned writes become a sequence of byte writes.
- Byte order is big-endian: the byte at the lowest address is bits [31:24] of a memory word.

Parameters:
- ABits, 13, memory byte-address width; used only for the address-range check (addresses are not masked).

Ports:
- clk  in  1  clock; memory writes and reads occur at its negedge.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- req_valid  in  1  request present.
- req_ready  out  1  high when the unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_width  in  2  00 byte, 01 half, 10 word, 11 invalid.
- req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores/errors.
- resp_err  out  1  invalid width or address >= 2**ABits; qualified by resp_valid.
- mem_daddr  out  32  memory byte address.
- mem_dwdata  out  32  memory write data.
- mem_drdata  in  32  memory read data; word-width, valid before the posedge ending the issue cycle.
- mem_dwe  out  1  memory write enable.
- mem_dwidth  out  2  memory access width (same encoding).

Behaviour:
- Reset state (rst_n low at posedge):
  - FSM -> IDLE; request registers cleared.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=1 once IDLE.
  - mem_dwe=0, mem_daddr=0, mem_dwdata=0, mem_dwidth=10.
- Reset mid-operation: the in-flight access is abandoned. No further memory cycles, no response; writes already issued stay in memory.
- Handshake:
  - req_ready = (state==IDLE).
  - A request is accepted at a posedge with req_valid && req_ready; all request fields are registered at that edge.
  - resp_valid is a single-cycle pulse with no backpressure. The FSM returns to IDLE in the same cycle.
- FSM states: IDLE, RD0, RD1, WR, RESP.
  - IDLE on accept:
    - error -> RESP;
    - load -> RD0;
    - store -> WR.
  - RD0: mem_daddr = addr & ~3, mem_dwidth = 10, mem_dwe = 0. Capture mem_drdata into hi at posedge. Go to RD1 if misaligned, else RESP.
  - RD1: mem_daddr = (addr & ~3) + 4, with 32-bit wrap. Capture lo, then RESP.
  - WR, aligned: one cycle. mem_daddr = addr, mem_dwidth = req_width, mem_dwe = 1, mem_dwdata = wdata. Then RESP.
  - WR, misaligned: N byte writes on consecutive cycles, N = 2 (half) or 4 (word), with a 2-bit counter.
    - Step i: mem_daddr = addr + i, mem_dwidth = 00.
    - mem_dwdata[7:0] = byte (N-1-i) of wdata, where byte 0 is bits [7:0].
    - After the last step -> RESP.
  - RESP: resp_valid = 1 for this cycle only, then IDLE. Memory outputs idle (mem_dwe = 0).
- Alignment rules:
  - A half is misaligned when addr[0] = 1.
  - A word is misaligned when addr[1:0] != 0.
  - A byte is never misaligned.
- Load extraction: form the 64-bit value {hi, lo} (lo = 0 when aligned).
  - Take the N bytes starting at byte offset addr[1:0] from the MSB end.
  - Sign- or zero-extend per req_signed; words are unaffected by req_signed.
- Latency from accept edge to resp_valid:
  - aligned load: 2 cycles;
  - misaligned load: 3 cycles;
  - aligned store: 2 cycles;
  - misaligned store: N+1 cycles;
  - error: 1 cycle.
- Errors: no memory cycle is issued; resp_rdata = 0.
- req_valid while not ready is ignored; the requester holds the request.

Test Plan:
1. Preload words 0x100 = 0x11223344, 0x104 = 0x55667788. lw 0x100 -> one read at 0x100; resp_valid 2 cycles after accept; rdata 0x11223344, err 0.
2. Misaligned lw 0x102 -> reads at 0x100 then 0x104; resp at cycle 3; rdata 0x33445566. lh unsigned 0x103 -> 0x00004455.
3. Loads at 0x107:
   - lb signed -> 0xFFFFFF88;
   - lb unsigned -> 0x00000088;
   - lh signed at 0x106 -> 0x00007788.
4. Misaligned sw 0xAABBCCDD at 0x101:
   - 4 byte writes, mem_daddr 0x101..0x104 with data AA, BB, CC, DD;
   - resp at cycle 5; req_ready low throughout;
   - readback 0x100 = 0x11AABBCC, 0x104 = 0xDD667788.
5. Width 11, and separately lw 0x2000 with ABits=13 -> resp_err = 1 one cycle after accept; mem_dwe never asserted; rdata 0.
6. Start sw 0xAABBCCDD at 0x101; drop rst_n after 2 byte writes:
   - mem_dwe = 0 from the next cycle; no resp_valid;
   - req_ready = 1 after rst_n returns high;
   - only bytes 0x101 and 0x102 modified.
